laundry_water_arbiter: RTL

LAUNDRY_WATER_ARBITER -- requirements
Module: laundry_water_arbiter

---
 rtl/laundry_water_arbiter_if.sv | 31 +++
 rtl/laundry_water_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/laundry_water_arbiter_if.sv
// laundry_water_arbiter_if
// Groups the machine-side signals of the shared water inlet arbiter.
//   fill_req          : per-machine request for water (machine fill valve open)
//   water_filled      : per-machine level-reached indication
//   fault_clear       : per-machine one-cycle pulse clearing that machine's fault
//   fill_grant        : one-hot grant, all zero when nothing is granted
//   supply_valve_open : main inlet valve, high only while a grant is active
//   grant_id          : index of the granted machine, held while idle
//   timeout_fault     : sticky per-machine fill-timeout flags
//   busy              : high while the arbiter is granting or in its release gap
// The master modport is the machine/controller side; the slave modport is the arbiter.
interface laundry_water_arbiter_if;
  logic [3:0] fill_req;
  logic [3:0] water_filled;
  logic [3:0] fault_clear;
  logic [3:0] fill_grant;
  logic       supply_valve_open;
  logic [1:0] grant_id;
  logic [3:0] timeout_fault;
  logic       busy;

  modport master (
    output fill_req, water_filled, fault_clear,
    input  fill_grant, supply_valve_open, grant_id, timeout_fault, busy
  );

  modport slave (
    input  fill_req, water_filled, fault_clear,
    output fill_grant, supply_valve_open, grant_id, timeout_fault, busy
  );
endinterface

// File: rtl/laundry_water_arbiter.sv
// laundry_water_arbiter
// Round-robin arbiter handing one shared water inlet to one of four machines at a
// time. A grant lasts until the machine is full or withdraws its request, or until
// MAX_FILL cycles have passed, in which case the machine is flagged with a sticky
// timeout fault and excluded from arbitration until its fault is cleared. Every
// grant is followed by GAP inlet-closed cycles.
// Ports:
//   clk   : single clock, all logic on the rising edge
//   reset : synchronous, active-high reset
//   bus   : machine-side signals (see laundry_water_arbiter_if)
module laundry_water_arbiter #(
  parameter int N_MACH   = 4,
  parameter int MAX_FILL = 64,
  parameter int GAP      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  laundry_water_arbiter_if.slave  bus
);

  localparam logic [7:0] FILL_LAST = 8'(MAX_FILL - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  fill_grant, fill_grant_nx;
  logic [1:0]  grant_id, grant_id_nx;
  logic [1:0]  rr_ptr, rr_ptr_nx;
  logic [7:0]  fill_cnt, fill_cnt_nx;
  logic [3:0]  gap_cnt, gap_cnt_nx;
  logic [3:0]  timeout_fault;
  logic [3:0]  fault_set;

  logic [N_MACH-1:0] eligible;
  logic              found;
  logic [1:0]        winner;
  logic [1:0]        idx;
  logic              normal_release;

  assign eligible = bus.fill_req & ~bus.water_filled & ~timeout_fault;

  // Round-robin search: first eligible machine at or after rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign normal_release = bus.water_filled[grant_id] || !bus.fill_req[grant_id];

  // Next-state logic. A normal release on the last fill cycle wins over the
  // timeout, so a machine that fills just in time is never faulted.
  always_comb begin
    state_nx      = state;
    fill_grant_nx = fill_grant;
    grant_id_nx   = grant_id;
    rr_ptr_nx     = rr_ptr;
    fill_cnt_nx   = fill_cnt;
    gap_cnt_nx    = gap_cnt;
    fault_set     = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx      = GRANT;
          fill_grant_nx = 4'b0001 << winner;
          grant_id_nx   = winner;
          rr_ptr_nx     = winner + 2'd1;
          fill_cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (normal_release) begin
          state_nx      = RELEASE;
          fill_grant_nx = '0;
          gap_cnt_nx    = '0;
        end else if (fill_cnt == FILL_LAST) begin
          state_nx            = RELEASE;
          fill_grant_nx       = '0;
          gap_cnt_nx          = '0;
          fault_set[grant_id] = 1'b1;
        end else begin
          fill_cnt_nx = fill_cnt + 8'd1;
        end
      end
      RELEASE: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 4'd1;
        end
      end
      default: begin
        state_nx      = IDLE;
        fill_grant_nx = '0;
      end
    endcase
  end

  // State and output registers. Reset closes the valve immediately, with no gap.
  // A new fault set in the same cycle as its clear pulse stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      fill_grant    <= '0;
      grant_id      <= '0;
      rr_ptr        <= '0;
      fill_cnt      <= '0;
      gap_cnt       <= '0;
      timeout_fault <= '0;
    end else begin
      state         <= state_nx;
      fill_grant    <= fill_grant_nx;
      grant_id      <= grant_id_nx;
      rr_ptr        <= rr_ptr_nx;
      fill_cnt      <= fill_cnt_nx;
      gap_cnt       <= gap_cnt_nx;
      timeout_fault <= (timeout_fault & ~bus.fault_clear) | fault_set;
    end
  end

  assign bus.fill_grant        = fill_grant;
  assign bus.supply_valve_open = |fill_grant;
  assign bus.grant_id          = grant_id;
  assign bus.timeout_fault     = timeout_fault;
  assign bus.busy              = (state != IDLE);

endmodule
